// File: rtl/ibex_xif_responder.sv
// Far end of the core's custom register side-channel: queues write pulses and
// returns a per-address running sum on the core's input channel.
module ibex_xif_responder #(
  parameter int FifoDepth    = 4,
  parameter int RespLatency  = 2,
  parameter int DropCntWidth = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           wr_valid_i,
  input  logic [4:0]                     wr_addr_i,
  input  logic [31:0]                    wr_data_i,
  output logic                           rsp_valid_o,
  output logic [4:0]                     rsp_addr_o,
  output logic [31:0]                    rsp_data_o,
  input  logic                           clear_i,
  output logic                           busy_o,
  output logic [$clog2(FifoDepth):0]     fifo_level_o,
  output logic                           overflow_o,
  output logic [DropCntWidth-1:0]        drop_cnt_o
);

  // state  | meaning
  // S_IDLE | waiting for a queued write; pops the FIFO head when one exists
  // S_WAIT | latency countdown for the popped write
  // S_RESP | response pulse on the outputs; shadow already holds the new sum

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int LvlW = $clog2(FifoDepth) + 1;
  localparam int CntW = (RespLatency > 2) ? $clog2(RespLatency - 1) : 1;
  localparam logic [CntW-1:0] CntLoad = (RespLatency >= 2) ? CntW'(RespLatency - 2) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [CntW-1:0]       r_cnt;
  logic [4:0]            r_addr;
  logic [31:0]           r_data;
  logic [31:0]           r_shadow [32];
  logic                  r_rsp_valid;
  logic [4:0]            r_rsp_addr;
  logic [31:0]           r_rsp_data;

  logic [36:0]           r_mem [FifoDepth];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [LvlW-1:0]       r_level;

  logic                  r_overflow;
  logic [DropCntWidth-1:0] r_drop_cnt;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [36:0]           w_head;
  logic [4:0]            w_src_addr;
  logic [31:0]           w_src_data;
  logic [31:0]           w_result;
  logic                  w_enter_resp;

  assign w_full = (r_level == LvlW'(FifoDepth));
  assign w_pop  = (r_state == S_IDLE) && (r_level != '0);
  // A full FIFO still accepts a write in the cycle its head is popped.
  assign w_push = wr_valid_i && (!w_full || w_pop);
  assign w_drop = wr_valid_i && !w_push;
  assign w_head = r_mem[r_rd_ptr];

  // With a one-cycle latency the response is built straight from the FIFO head.
  assign w_src_addr   = (r_state == S_IDLE) ? w_head[36:32] : r_addr;
  assign w_src_data   = (r_state == S_IDLE) ? w_head[31:0]  : r_data;
  assign w_result     = (w_src_addr == 5'd0) ? w_src_data : (r_shadow[w_src_addr] + w_src_data);
  assign w_enter_resp = ((r_state == S_WAIT) && (r_cnt == '0)) ||
                        ((RespLatency == 1) && w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_addr_i, wr_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LvlW'(1);
        2'b01:   r_level <= r_level - LvlW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
      for (int i = 0; i < 32; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_addr <= w_head[36:32];
            r_data <= w_head[31:0];
            if (RespLatency == 1) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= CntLoad;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_RESP;
          else             r_cnt   <= r_cnt - CntW'(1);
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Outputs and shadow are loaded on the edge into S_RESP; the next pop
      // cannot happen before S_IDLE, so later writes see the updated sum.
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_addr  <= w_src_addr;
        r_rsp_data  <= w_result;
        if (w_src_addr != 5'd0) begin
          r_shadow[w_src_addr] <= w_result;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear_i)              r_drop_cnt <= DropCntWidth'(1);
      else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DropCntWidth'(1);
    end else if (clear_i) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_addr_o   = r_rsp_addr;
  assign rsp_data_o   = r_rsp_data;
  assign busy_o       = (r_level != '0) || (r_state != S_IDLE);
  assign fifo_level_o = r_level;
  assign overflow_o   = r_overflow;
  assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_ibex_xif_responder.sv
// Scoreboard bench for ibex_xif_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares each response pulse.
module tb_ibex_xif_responder;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int DW = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic [4:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        clear_i = 1'b0;
  logic        rsp_valid_o;
  logic [4:0]  rsp_addr_o;
  logic [31:0] rsp_data_o;
  logic        busy_o;
  logic [$clog2(D):0] fifo_level_o;
  logic        overflow_o;
  logic [DW-1:0] drop_cnt_o;

  ibex_xif_responder #(.FifoDepth(D), .RespLatency(L), .DropCntWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_addr_o(rsp_addr_o), .rsp_data_o(rsp_data_o),
    .clear_i(clear_i), .busy_o(busy_o), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [4:0] a; logic [31:0] d; int c; } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  exp_t m_e;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rsp_valid_o) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got addr %0d data 0x%0h, expected no response",
                   rsp_addr_o, rsp_data_o);
        end else begin
          m_e = sb.pop_front();
          chk("rsp_addr", {27'd0, rsp_addr_o}, {27'd0, m_e.a});
          chk("rsp_data", rsp_data_o, m_e.d);
          if (m_e.c >= 0) chk("rsp_cycle", cyc, m_e.c);
        end
      end else if (rsp_addr_o != '0 || rsp_data_o != '0) begin
        chk("rsp_idle_addr", {27'd0, rsp_addr_o}, 32'd0);
        chk("rsp_idle_data", rsp_data_o, 32'd0);
      end
    end
  end

  task automatic write(input logic [4:0] a, input logic [31:0] d, input bit acc,
                       input logic [31:0] ed, input bit timed);
    exp_t e;
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    wr_data_i  = d;
    if (acc) begin
      e.a = a;
      e.d = ed;
      e.c = timed ? (cyc + 1 + L) : -1;
      sb.push_back(e);
    end
    @(posedge clk_i); #1;
    wr_valid_i = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic drain();
    int k = 0;
    while ((busy_o || sb.size() != 0) && k < 300) begin
      @(posedge clk_i); #1;
      k++;
    end
    idle(2);
    n_chk++;
    if (k >= 300) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending responses after %0d cycles, expected 0", sb.size(), k);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    chk({tag, "_level"}, 32'(fifo_level_o), 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow_o}, 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    check_reset_state("rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(1);
  endtask

  logic [31:0] b_exp [8]  = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21, 32'd0, 32'd29};
  bit          b_acc [8]  = '{1, 1, 1, 1, 1, 1, 0, 1};
  logic [31:0] s_exp [15] = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21, 32'd0, 32'd29,
                              32'd0, 32'd0, 32'd40, 32'd0, 32'd0, 32'd54, 32'd0};
  bit          s_acc [15] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0};

  initial begin
    #12;
    check_reset_state("por");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(2);

    // single write latency and accumulation
    write(5'd5, 32'h10, 1'b1, 32'h10, 1'b1);
    idle(6);
    write(5'd5, 32'h20, 1'b1, 32'h30, 1'b1);
    drain();

    // wrap-around and the addr 0 pass-through
    write(5'd7, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    write(5'd7, 32'h2, 1'b1, 32'h1, 1'b0);
    write(5'd0, 32'h5, 1'b1, 32'h5, 1'b0);
    write(5'd0, 32'h6, 1'b1, 32'h6, 1'b0);
    drain();

    // burst overflow: write 7 lands on a full FIFO with no pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      write(5'd3, 32'(i + 1), b_acc[i], b_exp[i], 1'b0);
      if (i == 6) chk("burst_level_full", 32'(fifo_level_o), 32'd4);
    end
    chk("burst_level_full_pop", 32'(fifo_level_o), 32'd4);
    chk("burst_overflow", {31'd0, overflow_o}, 32'd1);
    chk("burst_drop_cnt", 32'(drop_cnt_o), 32'd1);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    chk("clear_overflow", {31'd0, overflow_o}, 32'd0);
    chk("clear_drop_cnt", 32'(drop_cnt_o), 32'd0);
    chk("clear_level_kept", 32'(fifo_level_o), 32'd4);
    drain();

    // drop counter saturation, then clear racing a drop
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i == 14) clear_i = 1'b1;
      write(5'd9, 32'(i + 1), s_acc[i], s_exp[i], 1'b0);
      clear_i = 1'b0;
      if (i == 12) begin
        chk("sat_drop_cnt", 32'(drop_cnt_o), 32'd3);
        chk("sat_overflow", {31'd0, overflow_o}, 32'd1);
      end
    end
    chk("clear_vs_drop_cnt", 32'(drop_cnt_o), 32'd1);
    chk("clear_vs_drop_overflow", {31'd0, overflow_o}, 32'd1);
    drain();

    // reset while waiting with two entries queued
    do_reset();
    write(5'd5, 32'h7, 1'b1, 32'h7, 1'b1);
    write(5'd5, 32'h7, 1'b0, 32'h0, 1'b0);
    write(5'd5, 32'h7, 1'b0, 32'h0, 1'b0);
    write(5'd5, 32'h7, 1'b0, 32'h0, 1'b0);
    idle(1);
    chk("midrst_level_before", 32'(fifo_level_o), 32'd2);
    chk("midrst_busy_before", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("midrst_level", 32'(fifo_level_o), 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(10);
    chk("postrst_level", 32'(fifo_level_o), 32'd0);
    chk("postrst_busy", {31'd0, busy_o}, 32'd0);
    write(5'd5, 32'h1, 1'b1, 32'h1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation time %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end
endmodule
